muldiv_unit: RTL

Iterative multiply/divide unit that consumes the 4-bit mul_control code produced by the R-type ALU control decoder. It owns the architectural HI/LO registers. It executes MULT/MULTU/DIV/DIVU as a multi-cycle shift-add / restoring-division engine and accepts MTHI/MTLO writes. The pipeline stalls MFHI/MFLO and new mul/div issue while busy is high.

---
 rtl/muldiv_unit_pkg.sv | 23 ++
 rtl/muldiv_step.sv | 33 +++
 rtl/muldiv_unit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_unit_pkg;

    localparam logic [3:0] MULT_MC  = 4'b0001;
    localparam logic [3:0] MULTU_MC = 4'b0010;
    localparam logic [3:0] DIV_MC   = 4'b0100;
    localparam logic [3:0] DIVU_MC  = 4'b1000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PREP = 2'd1;
    localparam logic [1:0] ST_CALC = 2'd2;
    localparam logic [1:0] ST_FIX  = 2'd3;

    // Bits retired per CALC cycle must divide 32 evenly and stay small.
    function automatic logic step_legal(input int s);
        return (s == 1) || (s == 2) || (s == 4);
    endfunction

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: a shift-add multiply step or a
// restoring-divide step, retiring a single bit.
//   multiply: acc = {partial product high, multiplier remaining}
//   divide  : acc = {partial remainder, dividend bits -> quotient bits}
module muldiv_step (
    input  logic        is_div,
    input  logic [63:0] acc_i,
    input  logic [31:0] opb,
    output logic [63:0] acc_o
);

    logic [32:0] sum;
    logic [32:0] shifted;
    logic [31:0] diff;

    // Both candidate results are formed; is_div selects which one is retired.
    always_comb begin
        sum     = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, opb} : 33'd0);
        shifted = {acc_i[63:32], acc_i[31]};
        // When the subtract succeeds the remainder is below the divisor, so 32 bits suffice.
        diff    = shifted[31:0] - opb;
        if (is_div) begin
            if (shifted >= {1'b0, opb}) begin
                acc_o = {diff, acc_i[30:0], 1'b1};
            end else begin
                acc_o = {shifted[31:0], acc_i[30:0], 1'b0};
            end
        end else begin
            acc_o = {sum, acc_i[31:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
//
// state | meaning
// IDLE  | waiting for an op; MTHI/MTLO accepted here
// PREP  | take magnitudes, record sign fixes and divide-by-zero
// CALC  | STEP bits per cycle through the muldiv_step chain
// FIX   | apply sign fixes and write HI/LO (suppressed by cancel)
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  mul_control,
    input  logic        op_valid,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    if (!step_legal(STEP)) begin : g_bad_step
        $error("muldiv_unit: STEP must be 1, 2 or 4");
    end

    localparam logic [5:0] CNT_LAST = 6'(32 / STEP - 1);

    logic [1:0]  state_q, state_d;
    logic        op_div_q, op_div_d;
    logic        op_signed_q, op_signed_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opb_q, opb_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic        dbz_q, dbz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic [31:0] abs_a, abs_b;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;
    logic [63:0] chain [0:STEP];

    assign chain[0] = acc_q;

    for (genvar g = 0; g < STEP; g++) begin : g_step
        muldiv_step u_step (
            .is_div (op_div_q),
            .acc_i  (chain[g]),
            .opb    (opb_q),
            .acc_o  (chain[g+1])
        );
    end

    // Magnitudes and sign-fixed results; 0x80000000 maps onto itself unsigned.
    always_comb begin
        abs_a    = (op_signed_q && a_q[31]) ? (32'd0 - a_q) : a_q;
        abs_b    = (op_signed_q && b_q[31]) ? (32'd0 - b_q) : b_q;
        prod_fix = neg_quo_q ? (64'd0 - acc_q) : acc_q;
        quo_fix  = neg_quo_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
        rem_fix  = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
    end

    // FSM, counter, operand setup and HI/LO update.
    always_comb begin
        state_d     = state_q;
        op_div_d    = op_div_q;
        op_signed_d = op_signed_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        opb_d       = opb_q;
        cnt_d       = cnt_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        dbz_d       = dbz_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (op_valid && !cancel && is_onehot4(mul_control)) begin
                    op_div_d    = mul_control[2] | mul_control[3];
                    op_signed_d = mul_control[0] | mul_control[2];
                    a_d         = src_a;
                    b_d         = src_b;
                    state_d     = ST_PREP;
                end
            end
            ST_PREP: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else begin
                    // Multiplier / dividend shifts out of the low half of acc.
                    acc_d     = {32'd0, op_div_q ? abs_a : abs_b};
                    opb_d     = op_div_q ? abs_b : abs_a;
                    neg_quo_d = op_signed_q & (a_q[31] ^ b_q[31]);
                    neg_rem_d = op_signed_q & a_q[31];
                    dbz_d     = op_div_q & (b_q == 32'd0);
                    cnt_d     = 6'd0;
                    state_d   = ST_CALC;
                end
            end
            ST_CALC: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = chain[STEP];
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == CNT_LAST) state_d = ST_FIX;
                end
            end
            default: begin
                state_d = ST_IDLE;
                if (!cancel) begin
                    done_d = 1'b1;
                    if (!op_div_q) begin
                        hi_d = prod_fix[63:32];
                        lo_d = prod_fix[31:0];
                    end else if (dbz_q) begin
                        hi_d = a_q;
                        lo_d = 32'hFFFF_FFFF;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end
            end
        endcase
    end

    // State registers; reset discards any op in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            op_div_q    <= 1'b0;
            op_signed_q <= 1'b0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            acc_q       <= 64'd0;
            opb_q       <= 32'd0;
            cnt_q       <= 6'd0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            dbz_q       <= 1'b0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_div_q    <= op_div_d;
            op_signed_q <= op_signed_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            opb_q       <= opb_d;
            cnt_q       <= cnt_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            dbz_q       <= dbz_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            done_q      <= done_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
